// File: rtl/mm_avalon_csr.sv
// rtl/mm_avalon_csr.sv - Avalon-MM CSR front end for the matrix-multiplier core
// Streams A/B loads and C unloads via auto-incrementing pointers and runs the core FSM.
module mm_avalon_csr #(
  parameter int DATA_WIDTH   = 16,
  parameter int N_BANKS      = 3,
  parameter int ADDR_WIDTH_A = 4,
  parameter int ADDR_WIDTH_B = 4,
  parameter int ADDR_WIDTH_C = 4,
  parameter int ACC_WIDTH    = 34,
  parameter int C_RD_LAT     = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [3:0]                        avs_address,
  input  logic                              avs_chipselect,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [N_BANKS*DATA_WIDTH-1:0]     avs_writedata,
  input  logic [N_BANKS*DATA_WIDTH/8-1:0]   avs_byteenable,
  output logic [N_BANKS*DATA_WIDTH-1:0]     avs_readdata,
  output logic                              avs_readdatavalid,
  output logic                              avs_waitrequest,
  output logic                              irq,
  output logic                              core_start,
  output logic                              core_soft_rst,
  input  logic                              core_done,
  output logic                              a_en,
  output logic                              a_we,
  output logic [ADDR_WIDTH_A-1:0]           a_addr,
  output logic [N_BANKS*DATA_WIDTH-1:0]     a_din,
  output logic                              b_en,
  output logic                              b_we,
  output logic [ADDR_WIDTH_B-1:0]           b_addr,
  output logic [N_BANKS*DATA_WIDTH-1:0]     b_din,
  output logic                              c_rd_en,
  output logic [ADDR_WIDTH_C-1:0]           c_addr,
  input  logic [ACC_WIDTH-1:0]              c_dout
);

  localparam int W     = N_BANKS * DATA_WIDTH;
  localparam int BEW   = W / 8;
  localparam int CNT_W = $clog2(C_RD_LAT + 1);

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_STATUS = 4'd1;
  localparam logic [3:0] ADDR_A_PTR  = 4'd2;
  localparam logic [3:0] ADDR_A_DATA = 4'd3;
  localparam logic [3:0] ADDR_B_PTR  = 4'd4;
  localparam logic [3:0] ADDR_B_DATA = 4'd5;
  localparam logic [3:0] ADDR_C_PTR  = 4'd6;
  localparam logic [3:0] ADDR_C_DATA = 4'd7;
  localparam logic [3:0] ADDR_CYCLES = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q;
  logic                    irq_en_q, done_q, err_q;
  logic                    core_start_q, core_soft_rst_q;
  logic [ADDR_WIDTH_A-1:0] a_ptr_q, a_addr_q;
  logic [ADDR_WIDTH_B-1:0] b_ptr_q, b_addr_q;
  logic [ADDR_WIDTH_C-1:0] c_ptr_q;
  logic [W-1:0]            a_hold_q, b_hold_q, a_din_q, b_din_q;
  logic                    a_stb_q, b_stb_q;
  logic [31:0]             cycles_q;
  logic [CNT_W-1:0]        c_cnt_q;
  logic [W-1:0]            rdata_q;
  logic                    rvalid_q;

  logic         busy, access, c_req, rd_acc, wr_acc;
  logic [W-1:0] a_merge_d, b_merge_d, rdata_d;

  function automatic logic [W-1:0] lane_merge(input logic [W-1:0] old_v,
                                              input logic [W-1:0] new_v,
                                              input logic [BEW-1:0] be);
    logic [W-1:0] res;
    res = old_v;
    for (int i = 0; i < BEW; i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

  assign busy   = (state_q == S_RUN);
  assign access = avs_chipselect & (avs_read | avs_write);
  assign c_req  = avs_chipselect & avs_read & (avs_address == ADDR_C_DATA);

  // BRAM-facing addresses stall while the core owns the memories; C reads
  // additionally stall C_RD_LAT cycles to cover the core read latency.
  always_comb begin
    avs_waitrequest = 1'b0;
    if (access && busy && (avs_address == ADDR_A_DATA || avs_address == ADDR_B_DATA ||
                           avs_address == ADDR_C_DATA))
      avs_waitrequest = 1'b1;
    else if (c_req && (c_cnt_q != CNT_W'(C_RD_LAT)))
      avs_waitrequest = 1'b1;
  end

  assign rd_acc  = avs_chipselect & avs_read & ~avs_waitrequest;
  assign wr_acc  = avs_chipselect & avs_write & ~avs_waitrequest;
  assign c_rd_en = c_req & ~busy & (c_cnt_q == '0);
  assign c_addr  = c_ptr_q;

  assign a_merge_d = lane_merge(a_hold_q, avs_writedata, avs_byteenable);
  assign b_merge_d = lane_merge(b_hold_q, avs_writedata, avs_byteenable);

  always_comb begin
    rdata_d = '0;
    case (avs_address)
      ADDR_CTRL:   rdata_d = W'({irq_en_q, 2'b00});
      ADDR_STATUS: rdata_d = W'({err_q, busy, done_q});
      ADDR_A_PTR:  rdata_d = W'(a_ptr_q);
      ADDR_B_PTR:  rdata_d = W'(b_ptr_q);
      ADDR_C_PTR:  rdata_d = W'(c_ptr_q);
      ADDR_C_DATA: rdata_d = W'(c_dout);
      ADDR_CYCLES: rdata_d = W'(cycles_q);
      default:     rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      irq_en_q        <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      core_start_q    <= 1'b0;
      core_soft_rst_q <= 1'b0;
      a_ptr_q         <= '0;
      a_addr_q        <= '0;
      b_ptr_q         <= '0;
      b_addr_q        <= '0;
      c_ptr_q         <= '0;
      a_hold_q        <= '0;
      b_hold_q        <= '0;
      a_din_q         <= '0;
      b_din_q         <= '0;
      a_stb_q         <= 1'b0;
      b_stb_q         <= 1'b0;
      cycles_q        <= '0;
      c_cnt_q         <= '0;
      rdata_q         <= '0;
      rvalid_q        <= 1'b0;
    end else begin
      core_start_q    <= 1'b0;
      core_soft_rst_q <= 1'b0;
      a_stb_q         <= 1'b0;
      b_stb_q         <= 1'b0;
      rvalid_q        <= 1'b0;

      c_cnt_q <= (c_req && !busy && c_cnt_q != CNT_W'(C_RD_LAT)) ? c_cnt_q + 1'b1 : '0;

      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        if (avs_address == ADDR_C_DATA) c_ptr_q <= c_ptr_q + 1'b1;
      end

      // W1C comes first so a same-cycle set event below overrides it.
      if (wr_acc && avs_address == ADDR_STATUS) begin
        if (avs_writedata[0]) done_q <= 1'b0;
        if (avs_writedata[2]) err_q  <= 1'b0;
      end

      if (state_q == S_RUN) begin
        if (cycles_q != 32'hFFFF_FFFF) cycles_q <= cycles_q + 32'd1;
        if (core_done) begin
          state_q <= S_IDLE;
          done_q  <= 1'b1;
        end
      end

      if (wr_acc) begin
        case (avs_address)
          ADDR_CTRL: begin
            irq_en_q <= avs_writedata[2];
            if (avs_writedata[1]) begin
              core_soft_rst_q <= 1'b1;
              state_q         <= S_IDLE;
              done_q          <= done_q;
              cycles_q        <= '0;
            end else if (avs_writedata[0]) begin
              if (state_q == S_IDLE) begin
                state_q      <= S_RUN;
                core_start_q <= 1'b1;
                cycles_q     <= '0;
                done_q       <= 1'b0;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          ADDR_A_PTR: a_ptr_q <= avs_writedata[ADDR_WIDTH_A-1:0];
          ADDR_B_PTR: b_ptr_q <= avs_writedata[ADDR_WIDTH_B-1:0];
          ADDR_C_PTR: c_ptr_q <= avs_writedata[ADDR_WIDTH_C-1:0];
          ADDR_A_DATA: begin
            a_hold_q <= a_merge_d;
            a_din_q  <= a_merge_d;
            a_addr_q <= a_ptr_q;
            a_stb_q  <= 1'b1;
            a_ptr_q  <= a_ptr_q + 1'b1;
          end
          ADDR_B_DATA: begin
            b_hold_q <= b_merge_d;
            b_din_q  <= b_merge_d;
            b_addr_q <= b_ptr_q;
            b_stb_q  <= 1'b1;
            b_ptr_q  <= b_ptr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign irq               = done_q & irq_en_q;
  assign core_start        = core_start_q;
  assign core_soft_rst     = core_soft_rst_q;
  assign a_en              = a_stb_q;
  assign a_we              = a_stb_q;
  assign a_addr            = a_addr_q;
  assign a_din             = a_din_q;
  assign b_en              = b_stb_q;
  assign b_we              = b_stb_q;
  assign b_addr            = b_addr_q;
  assign b_din             = b_din_q;

endmodule

// File: tb/tb_mm_avalon_csr.sv
// tb/tb_mm_avalon_csr.sv - directed self-checking bench for mm_avalon_csr
module tb_mm_avalon_csr;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  avs_address;
  logic        avs_chipselect, avs_read, avs_write;
  logic [47:0] avs_writedata;
  logic [5:0]  avs_byteenable;
  logic [47:0] avs_readdata;
  logic        avs_readdatavalid, avs_waitrequest, irq;
  logic        core_start, core_soft_rst, core_done;
  logic        a_en, a_we, b_en, b_we, c_rd_en;
  logic [3:0]  a_addr, b_addr, c_addr;
  logic [47:0] a_din, b_din;
  logic [33:0] c_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mm_avalon_csr #(
    .DATA_WIDTH(16), .N_BANKS(3), .ADDR_WIDTH_A(4), .ADDR_WIDTH_B(4),
    .ADDR_WIDTH_C(4), .ACC_WIDTH(34), .C_RD_LAT(2)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_address(avs_address), .avs_chipselect(avs_chipselect),
    .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .avs_waitrequest(avs_waitrequest), .irq(irq),
    .core_start(core_start), .core_soft_rst(core_soft_rst), .core_done(core_done),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din),
    .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din),
    .c_rd_en(c_rd_en), .c_addr(c_addr), .c_dout(c_dout)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_accept(input string tag);
    int n = 0;
    #1;
    while (avs_waitrequest && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=waitrequest_stuck exp=accept", tag);
    end
  endtask

  task automatic bus_write(input logic [3:0] addr, input logic [47:0] data, input logic [5:0] be);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1;
    avs_address = addr; avs_writedata = data; avs_byteenable = be;
    wait_accept("wr");
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic [47:0] exp);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = addr;
    wait_accept(tag);
    @(posedge clk);
    #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    check({tag, "_valid"}, avs_readdatavalid, 1);
    check(tag, avs_readdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    avs_address = '0; avs_chipselect = 0; avs_read = 0; avs_write = 0;
    avs_writedata = '0; avs_byteenable = '0; core_done = 0; c_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", avs_readdata, 0);
    check("rst_rvalid", avs_readdatavalid, 0);
    check("rst_irq", irq, 0);
    check("rst_start", core_start, 0);
    check("rst_a_we", a_we, 0);
    check("rst_wait", avs_waitrequest, 0);
    reset = 1'b0;

    // A streaming loads
    bus_write(4'd2, 48'd0, 6'h3f);
    for (int i = 0; i < 3; i++) begin
      bus_write(4'd3, 48'h0001_0002_0003, 6'h3f);
      check("a_we", a_we, 1);
      check("a_en", a_en, 1);
      check("a_addr", a_addr, i);
      check("a_din", a_din, 48'h0001_0002_0003);
    end
    read_check("a_ptr3", 4'd2, 48'd3);

    // pointer wrap
    bus_write(4'd2, 48'd15, 6'h3f);
    bus_write(4'd3, 48'h0000_0000_0001, 6'h3f);
    check("a_addr_wrap15", a_addr, 15);
    bus_write(4'd3, 48'h0000_0000_0002, 6'h3f);
    check("a_addr_wrap0", a_addr, 0);
    read_check("a_ptr_wrap", 4'd2, 48'd1);

    // byte-lane merge over held data
    bus_write(4'd3, 48'd0, 6'h3f);
    bus_write(4'd3, 48'hAAAA_AAAA_FFFF, 6'b000011);
    check("a_din_be_lo", a_din, 48'h0000_0000_FFFF);
    bus_write(4'd3, 48'h5555_1234_5678, 6'b110000);
    check("a_din_be_hi", a_din, 48'h5555_0000_FFFF);

    // B port
    bus_write(4'd4, 48'd2, 6'h3f);
    bus_write(4'd5, 48'h1111_2222_3333, 6'h3f);
    check("b_we", b_we, 1);
    check("b_addr", b_addr, 2);
    check("b_din", b_din, 48'h1111_2222_3333);
    read_check("b_ptr", 4'd4, 48'd3);

    // run with irq, CYCLES = 11
    bus_write(4'd0, 48'h5, 6'h3f);
    check("run_start_pulse", core_start, 1);
    @(posedge clk); #1;
    check("run_start_once", core_start, 0);
    repeat (9) @(posedge clk);
    #1; core_done = 1'b1;
    @(posedge clk); #1; core_done = 1'b0;
    check("run_irq", irq, 1);
    read_check("run_status", 4'd1, 48'h1);
    read_check("run_cycles", 4'd8, 48'd11);
    read_check("run_ctrl", 4'd0, 48'h4);
    bus_write(4'd1, 48'h1, 6'h3f);
    check("w1c_irq", irq, 0);
    read_check("w1c_status", 4'd1, 48'h0);

    // start in RUN -> err, C read stalled until done
    bus_write(4'd0, 48'h5, 6'h3f);
    check("run2_start", core_start, 1);
    read_check("run2_busy", 4'd1, 48'h2);
    bus_write(4'd0, 48'h5, 6'h3f);
    check("run2_no_restart", core_start, 0);
    read_check("run2_err", 4'd1, 48'h6);
    c_dout = 34'h1_2345_6789;
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 4'd7;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("busy_c_wait", avs_waitrequest, 1);
      check("busy_c_rd_en", c_rd_en, 0);
      @(negedge clk); #1;
    end
    core_done = 1'b1;
    @(posedge clk); #1; core_done = 1'b0;
    check("c0_rd_en", c_rd_en, 1);
    check("c0_wait_t0", avs_waitrequest, 1);
    check("c0_addr", c_addr, 0);
    @(posedge clk); #1;
    check("c0_wait_t1", avs_waitrequest, 1);
    check("c0_rd_en_t1", c_rd_en, 0);
    @(posedge clk); #1;
    check("c0_wait_t2", avs_waitrequest, 0);
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    check("c0_valid", avs_readdatavalid, 1);
    check("c0_data", avs_readdata, 48'h0001_2345_6789);
    read_check("c_ptr1", 4'd6, 48'd1);
    read_check("run2_status_end", 4'd1, 48'h5);
    bus_write(4'd1, 48'h5, 6'h3f);
    read_check("w1c_both", 4'd1, 48'h0);

    // C read latency at C_PTR=5
    bus_write(4'd6, 48'd5, 6'h3f);
    c_dout = 34'h3_FFFF_FFFF;
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 4'd7;
    #1;
    check("c5_rd_en", c_rd_en, 1);
    check("c5_addr", c_addr, 5);
    n = 0;
    while (avs_waitrequest && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("c5_wait_cycles", n, 2);
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    check("c5_valid", avs_readdatavalid, 1);
    check("c5_data", avs_readdata, 48'h0003_FFFF_FFFF);
    @(posedge clk); #1;
    check("c5_valid_drop", avs_readdatavalid, 0);
    read_check("c_ptr6", 4'd6, 48'd6);

    // soft reset beats start, pointers kept
    bus_write(4'd0, 48'h5, 6'h3f);
    repeat (3) @(posedge clk);
    bus_write(4'd0, 48'h7, 6'h3f);
    check("srst_pulse", core_soft_rst, 1);
    check("srst_no_start", core_start, 0);
    @(posedge clk); #1;
    check("srst_once", core_soft_rst, 0);
    read_check("srst_status", 4'd1, 48'h0);
    read_check("srst_cycles", 4'd8, 48'd0);
    read_check("srst_a_ptr", 4'd2, 48'd4);

    read_check("undef_addr", 4'd9, 48'd0);

    // reset mid-run
    bus_write(4'd0, 48'h5, 6'h3f);
    read_check("pre_rst_ctrl", 4'd0, 48'h4);
    reset = 1'b1;
    #1;
    check("mid_rst_start", core_start, 0);
    check("mid_rst_readdata", avs_readdata, 0);
    check("mid_rst_rvalid", avs_readdatavalid, 0);
    check("mid_rst_irq", irq, 0);
    @(negedge clk);
    reset = 1'b0;
    read_check("post_rst_status", 4'd1, 48'h0);
    read_check("post_rst_ctrl", 4'd0, 48'h0);
    read_check("post_rst_a_ptr", 4'd2, 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_avalon_csr.md
Name: mm_avalon_csr

Overview:
- Second-generation Avalon-MM slave front end for the matrix-multiplier core.
- Adds four things over a plain register shim:
  - auto-incrementing A/B/C pointers for burst-free streaming loads and unloads;
  - a run-control FSM with busy/done/error status;
  - a maskable completion interrupt;
  - a cycle counter.
- Pipelined reads with readdatavalid; parameterised bank count, widths and C read latency.
- Sits between the Nios II interconnect and the core's BRAM load ports and control.

Parameters:
- DATA_WIDTH, 16, element width.
- N_BANKS, 3, BRAM banks; Avalon data width W = N_BANKS*DATA_WIDTH.
- ADDR_WIDTH_A, 4, A load-address width.
- ADDR_WIDTH_B, 4, B load-address width.
- ADDR_WIDTH_C, 4, C read-address width.
- ACC_WIDTH, 34, C element width; must be <= W.
- C_RD_LAT, 2, core C-read latency in cycles; must be >= 1.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- avs_address  in  4  word address.
- avs_chipselect  in  1  slave select.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  W  write data.
- avs_byteenable  in  W/8  byte lanes.
- avs_readdata  out  W  read data, registered.
- avs_readdatavalid  out  1  read data valid.
- avs_waitrequest  out  1  stall.
- irq  out  1  level interrupt: done & irq_en.
- core_start  out  1  one-cycle start pulse.
- core_soft_rst  out  1  one-cycle core reset pulse.
- core_done  in  1  completion, sampled while RUN.
- a_en, a_we  out  1 each  A load strobes.
- a_addr  out  ADDR_WIDTH_A  A load address.
- a_din  out  W  A load data.
- b_en, b_we  out  1 each  B load strobes.
- b_addr  out  ADDR_WIDTH_B  B load address.
- b_din  out  W  B load data.
- c_rd_en  out  1  C read strobe.
- c_addr  out  ADDR_WIDTH_C  C read address.
- c_dout  in  ACC_WIDTH  C read data.

Behaviour:

Register map (word address):
- 0 CTRL:
  - W: [0] start (pulse), [1] soft_rst (pulse), [2] irq_en (sticky).
  - R: returns {irq_en, 2'b0}.
- 1 STATUS:
  - R: [0] done (sticky), [1] busy, [2] err (sticky).
  - W1C on bits [0] and [2].
- 2 A_PTR, 4 B_PTR, 6 C_PTR: RW, zero-extended on read.
- 3 A_DATA, 5 B_DATA: W only.
  - Byte-lane merge into the held data register.
  - Next cycle: en=we=1, addr=PTR, din=merged data.
  - PTR then increments modulo 2^ADDR_WIDTH.
- 7 C_DATA: R only; see read path below.
- 8 CYCLES: R; 32-bit count of cycles spent in RUN for the last or current run; saturates at 0xFFFFFFFF.
- Undefined addresses: writes are ignored; reads return 0 with readdatavalid.

FSM (IDLE, RUN):
- IDLE -> RUN on start write. core_start pulses the next cycle; CYCLES and done clear.
- RUN -> IDLE on core_done=1. done sets.
- start written in RUN: ignored and err sets.
- soft_rst from any state:
  - core_soft_rst pulses one cycle;
  - FSM -> IDLE; done not set; CYCLES=0;
  - pointers are kept.
- If start=1 and soft_rst=1 in the same write, soft_rst wins.

Read path:
- Register reads:
  - waitrequest=0;
  - readdatavalid and readdata are registered one cycle after acceptance.
- C_DATA read (request first presented at t0):
  - c_rd_en=1 and c_addr=C_PTR at t0 only, combinational;
  - waitrequest=1 for t0..t0+C_RD_LAT-1 and 0 at t0+C_RD_LAT (accept);
  - readdata = zero-extended c_dout at t0+C_RD_LAT+1 with readdatavalid=1;
  - C_PTR increments on accept.

Stalls and ordering:
- Any access to addresses 3, 5 or 7 while busy holds waitrequest=1 until IDLE, because the core owns the BRAMs.
- A STATUS W1C in the same cycle as a done/err set event: set wins.

Reset values:
- All outputs 0, including avs_readdata and irq.
- All registers 0; FSM IDLE.
- Reset mid-run aborts immediately with no core_start or done.

Test Plan:
- Write A_PTR=0. Write A_DATA 0x0001_0002_0003 three times. Expect a_we pulses with addresses 0,1,2, din matching each write, and A_PTR reads back 3.
- Set A_PTR=15 (ADDR_WIDTH_A=4), then write A_DATA twice. Expect addresses 15 then 0.
- Write A_DATA with byteenable=6'b000011 and data 0xFFFF over held data 0. Expect a_din=0x00000000FFFF.
- Write CTRL=0x5 (irq_en and start). Expect one core_start pulse and busy=1. Hold core_done low 10 cycles, then pulse it. Expect done=1, irq=1 and CYCLES=11. W1C STATUS=1 -> irq=0.
- Write start while in RUN. Expect err=1, no second core_start, and C_DATA reads stalled until done.
- C_RD_LAT=2, C_PTR=5, c_dout=0x3_FFFF_FFFF. Expect waitrequest high 2 cycles, c_addr=5, readdatavalid 3 cycles after t0 with that value, and C_PTR=6.
- Assert reset mid-RUN. Expect all outputs 0 and the FSM in IDLE.
